inst_fetch: RTL and testbench

//  Fetch unit (IF stage): producer side of the instruction buffer between IF and ID.

---
 rtl/inst_fetch.sv | 141 ++++++++++++++
 tb/tb_inst_fetch.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: IF stage, PC generation and aligned 8-byte fetches into the IF/ID buffer.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (trap on misaligned redirect target).
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    output logic [31:0] inst_out1,
    output logic [31:0] inst_out2,
    output logic [31:0] inst_pc1,
    output logic [31:0] inst_pc2,
    output logic        inst_valid1,
    output logic        inst_valid2,
    input  logic        instbuf_full,
    input  logic        branch_flag,
    input  logic [31:0] branch_pc,
    output logic        fetch_misalign
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic [31:0] req_pc;
    logic [63:0] hold;
    logic        accept;
    logic        push;
    logic        active;
    logic        odd;
    logic        park;
    logic        stop;
    logic        take_br;
    logic [31:0] br_target;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign;
    logic br_bad;

    assign br_bad    = branch_flag && (branch_pc[1:0] != 2'b00);
    assign park      = misalign;
    assign stop      = misalign || br_bad;
    assign take_br   = branch_flag && !stop;
    assign br_target = branch_pc;

    // sticky trap: once set, fetching stays parked until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else if (br_bad) begin
            misalign <= 1'b1;
        end
    end

    assign fetch_misalign = rst && misalign;
`else
    logic unused_bits;

    assign park           = 1'b0;
    assign stop           = 1'b0;
    assign take_br        = branch_flag;
    assign br_target      = {branch_pc[31:2], 2'b00};
    assign fetch_misalign = 1'b0;
    assign unused_bits    = ^branch_pc[1:0];
`endif

    assign imem_req  = rst && (state == REQ) && !park;
    assign imem_addr = {pc[31:3], 3'b000};
    assign accept    = imem_req && imem_ready;
    assign push      = (state == HOLD) && !instbuf_full && !branch_flag;

    // fetch sequencing; a redirect overrides the normal flow in every state
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        unique case (state)
            REQ:  if (accept) state_nx = WAIT;
            WAIT: if (imem_rvalid) state_nx = HOLD;
            HOLD: begin
                if (push) begin
                    state_nx = REQ;
                    pc_nx    = {pc[31:3] + 29'd1, 3'b000};
                end
            end
            DROP: if (imem_rvalid) state_nx = REQ;
            default: state_nx = REQ;
        endcase
        if (branch_flag) begin
            pc_nx = take_br ? br_target : pc;
            unique case (state)
                REQ:        state_nx = accept ? DROP : REQ;
                WAIT, DROP: state_nx = imem_rvalid ? REQ : DROP;
                default:    state_nx = REQ;
            endcase
        end
        if (stop) begin
            state_nx = REQ;
        end
    end

    // state, PC, request PC and fetched-data holding registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
            hold   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (accept) begin
                req_pc <= pc;
            end
            if ((state == WAIT) && imem_rvalid) begin
                hold <= imem_rdata;
            end
        end
    end

    // an odd start word leaves only the upper slot of the fetch usable
    assign odd         = req_pc[2];
    assign active      = rst && (state == HOLD) && !branch_flag;
    assign inst_valid1 = active && !odd;
    assign inst_valid2 = active;
    assign inst_out1   = inst_valid1 ? hold[31:0] : '0;
    assign inst_pc1    = inst_valid1 ? req_pc : '0;
    assign inst_out2   = active ? hold[63:32] : '0;
    assign inst_pc2    = !active ? '0 : (odd ? req_pc : req_pc + 32'd4);

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a latency-programmable memory.
// Inputs change 1ns after posedge; outputs are sampled 1ns after negedge.
module tb_inst_fetch;

    typedef struct packed {
        logic        v1;
        logic        v2;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] p1;
        logic [31:0] p2;
    } push_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [63:0] imem_rdata = '0;
    logic [31:0] inst_out1;
    logic [31:0] inst_out2;
    logic [31:0] inst_pc1;
    logic [31:0] inst_pc2;
    logic        inst_valid1;
    logic        inst_valid2;
    logic        instbuf_full = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        fetch_misalign;

    int          checks = 0;
    int          errors = 0;
    logic        ready_knob = 1'b0;
    int          mem_lat = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    push_t       exp_q[$];
    push_t       obs_q[$];

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_out1     (inst_out1),
        .inst_out2     (inst_out2),
        .inst_pc1      (inst_pc1),
        .inst_pc2      (inst_pc2),
        .inst_valid1   (inst_valid1),
        .inst_valid2   (inst_valid2),
        .instbuf_full  (instbuf_full),
        .branch_flag   (branch_flag),
        .branch_pc     (branch_pc),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic push_t pair(input logic [31:0] a);
        return {1'b1, 1'b1, mem_word(a), mem_word(a + 32'd4), a, a + 32'd4};
    endfunction

    // memory: one response per accepted request, mem_lat extra cycles late
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            pend = 0;
            cnt = 0;
            imem_rvalid = 1'b0;
            imem_ready = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = {mem_word(paddr + 32'd4), mem_word(paddr)};
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            imem_ready = ready_knob;
            if (imem_req && imem_ready) begin
                pend = 1;
                paddr = imem_addr;
                cnt = mem_lat;
            end
        end
    end

    // record every accepted push into the buffer
    always @(negedge clk) begin
        if (rst && (inst_valid1 || inst_valid2) && !instbuf_full && !branch_flag)
            obs_q.push_back({inst_valid1, inst_valid2, inst_out1, inst_out2,
                             inst_pc1, inst_pc2});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_push(input int budget, output bit ok);
        int k = 0;
        while (obs_q.size() == 0 && k < budget) begin
            smp();
            k++;
        end
        ok = (obs_q.size() != 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ready_knob = 1'b1;
        mem_lat = 0;
        repeat (3) tick();
        smp();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b exp 0", imem_req);
        end
        checks++;
        if ({inst_valid1, inst_valid2} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid got %b exp 00", {inst_valid1, inst_valid2});
        end
        checks++;
        if ({inst_out1, inst_out2, inst_pc1, inst_pc2} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0",
                     {inst_out1, inst_out2, inst_pc1, inst_pc2});
        end
        checks++;
        if (fetch_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_misalign got %b exp 0", fetch_misalign);
        end
    endtask

    task automatic test_fetch();
        push_t got;
        push_t ex;
        bit ok;
        exp_q.push_back({1'b1, 1'b1, 32'h0000_0093, 32'h0010_0113, 32'h0, 32'h4});
        tick();
        rst = 1'b1;
        smp();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL t1_first_req got %b/%h exp 1/0", imem_req, imem_addr);
        end
        wait_push(20, ok);
        ex = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t1_push got none exp %h", ex);
        end else begin
            got = obs_q.pop_front();
            if (got !== ex) begin
                errors++;
                $display("FAIL t1_push got %h exp %h", got, ex);
            end
        end
        smp();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL t1_next_addr got %b/%h exp 1/8", imem_req, imem_addr);
        end
    endtask

    task automatic test_backpressure();
        push_t got;
        push_t ex;
        bit ok;
        int k;
        exp_q.push_back(pair(32'h8));
        tick();
        instbuf_full = 1'b1;
        k = 0;
        while (inst_valid2 !== 1'b1 && k < 10) begin
            smp();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({inst_valid1, inst_valid2, inst_out1, inst_out2, inst_pc1, inst_pc2,
                 imem_req} !== {pair(32'h8), 1'b0} || obs_q.size() != 0) begin
                errors++;
                $display("FAIL t2_hold%0d got %h req %b n %0d exp %h req 0", i,
                         {inst_valid1, inst_valid2, inst_out1, inst_out2,
                          inst_pc1, inst_pc2}, imem_req, obs_q.size(), pair(32'h8));
            end
            smp();
        end
        tick();
        instbuf_full = 1'b0;
        ready_knob = 1'b0;
        wait_push(10, ok);
        ex = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t2_push got none exp %h", ex);
        end else begin
            got = obs_q.pop_front();
            if (got !== ex) begin
                errors++;
                $display("FAIL t2_push got %h exp %h", got, ex);
            end
        end
        smp();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10} || obs_q.size() != 0) begin
            errors++;
            $display("FAIL t2_next_addr got %b/%h n %0d exp 1/10 n 0",
                     imem_req, imem_addr, obs_q.size());
        end
    endtask

    task automatic test_odd_start();
        push_t got;
        push_t ex;
        bit ok;
        exp_q.push_back({1'b0, 1'b1, 32'h0, mem_word(32'h104), 32'h0, 32'h104});
        tick();
        branch_flag = 1'b1;
        branch_pc = 32'h0000_0104;
        tick();
        branch_flag = 1'b0;
        ready_knob = 1'b1;
        smp();
        checks++;
        if (imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL t3_addr got %h exp 100", imem_addr);
        end
        wait_push(10, ok);
        ex = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t3_push got none exp %h", ex);
        end else begin
            got = obs_q.pop_front();
            if (got !== ex) begin
                errors++;
                $display("FAIL t3_push got %h exp %h", got, ex);
            end
        end
        tick();
        ready_knob = 1'b0;
        smp();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h108}) begin
            errors++;
            $display("FAIL t3_next_addr got %b/%h exp 1/108", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        int k;
        mem_lat = 3;
        tick();
        ready_knob = 1'b1;
        k = 0;
        smp();
        while (imem_req !== 1'b0 && k < 10) begin
            smp();
            k++;
        end
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL t4_accept got req %b exp 0", imem_req);
        end
        tick();
        branch_flag = 1'b1;
        branch_pc = 32'h0000_0200;
        ready_knob = 1'b0;
        tick();
        branch_flag = 1'b0;
        repeat (8) smp();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL t4_no_push got %0d pushes exp 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
            errors++;
            $display("FAIL t4_next_addr got %b/%h exp 1/200", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        push_t got;
        push_t ex;
        bit ok;
        mem_lat = 0;
        exp_q.push_back(pair(32'hFFFF_FFF8));
        tick();
        branch_flag = 1'b1;
        branch_pc = 32'h0000_0300;
        tick();
        branch_pc = 32'hFFFF_FFF8;
        tick();
        branch_flag = 1'b0;
        ready_knob = 1'b1;
        smp();
        checks++;
        if (imem_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL t5_last_target got %h exp fffffff8", imem_addr);
        end
        wait_push(10, ok);
        ex = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t5_push got none exp %h", ex);
        end else begin
            got = obs_q.pop_front();
            if (got !== ex) begin
                errors++;
                $display("FAIL t5_push got %h exp %h", got, ex);
            end
        end
        tick();
        ready_knob = 1'b0;
        smp();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL t5_wrap_addr got %b/%h exp 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        push_t got;
        push_t ex;
        bit ok;
        int k;
        mem_lat = 2;
        tick();
        ready_knob = 1'b1;
        k = 0;
        smp();
        while (imem_req !== 1'b0 && k < 10) begin
            smp();
            k++;
        end
        tick();
        rst = 1'b0;
        tick();
        smp();
        checks++;
        if ({imem_req, inst_valid1, inst_valid2, inst_out2, inst_pc2} !== 67'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b%b%b %h %h exp all 0", imem_req,
                     inst_valid1, inst_valid2, inst_out2, inst_pc2);
        end
        mem_lat = 0;
        exp_q.push_back(pair(32'h0));
        tick();
        rst = 1'b1;
        wait_push(20, ok);
        ex = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_push got none exp %h", ex);
        end else begin
            got = obs_q.pop_front();
            if (got !== ex) begin
                errors++;
                $display("FAIL rst_mid_push got %h exp %h", got, ex);
            end
        end
        tick();
        ready_knob = 1'b0;
        smp();
    endtask

    task automatic test_misalign();
        tick();
        branch_flag = 1'b1;
        branch_pc = 32'h0000_0202;
        tick();
        branch_flag = 1'b0;
        smp();
`ifdef FETCH_MISALIGN_CHK_EN
        checks++;
        if ({fetch_misalign, imem_req} !== 2'b10) begin
            errors++;
            $display("FAIL t6_trap got misalign %b req %b exp 1 0",
                     fetch_misalign, imem_req);
        end
        tick();
        ready_knob = 1'b1;
        repeat (6) smp();
        checks++;
        if ({fetch_misalign, imem_req} !== 2'b10 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL t6_parked got misalign %b req %b n %0d exp 1 0 0",
                     fetch_misalign, imem_req, obs_q.size());
        end
`else
        begin
            push_t got;
            push_t ex;
            bit ok;
            checks++;
            if ({fetch_misalign, imem_req, imem_addr} !== {2'b01, 32'h200}) begin
                errors++;
                $display("FAIL t6_ignored got misalign %b req %b addr %h exp 0 1 200",
                         fetch_misalign, imem_req, imem_addr);
            end
            exp_q.push_back(pair(32'h200));
            tick();
            ready_knob = 1'b1;
            wait_push(10, ok);
            ex = exp_q.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL t6_push got none exp %h", ex);
            end else begin
                got = obs_q.pop_front();
                if (got !== ex) begin
                    errors++;
                    $display("FAIL t6_push got %h exp %h", got, ex);
                end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_odd_start();
        test_redirect_wait();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
